// File: rtl/nco_sched_pkg.sv
// Shared types and default widths for the NCO frame scheduler.
package nco_sched_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_PHASE_W = 10;
    localparam int DEF_FTW_W   = 10;
    localparam int DEF_DATA_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Channel index width; a single channel still needs one tag bit.
    function automatic int ch_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CH_IDX_W = ch_idx_w(DEF_NUM_CH);

endpackage

// File: rtl/nco_phase_bank.sv
// Per-channel phase accumulators with slot load/advance, read mux and
// frame-sync clear. The read returns the pre-increment phase of the slot
// being loaded, so the converter sees acc[i] while acc[i] steps forward.
module nco_phase_bank
    import nco_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int FTW_W   = DEF_FTW_W,
    parameter int IDX_W   = ch_idx_w(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    adv,
    input  logic [IDX_W-1:0]        idx,
    input  logic [NUM_CH*FTW_W-1:0] ftw,
    input  logic                    sync_clr,
    output logic [PHASE_W-1:0]      rd_phase
);

    logic [NUM_CH-1:0][PHASE_W-1:0] acc;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PHASE_W-1:0] acc_q;
        logic [PHASE_W-1:0] inc;
        logic               hit;

        assign inc    = PHASE_W'(ftw[g*FTW_W +: FTW_W]);
        assign hit    = load && adv && (idx == IDX_W'(g));
        assign acc[g] = acc_q;

        // Sync clears every channel (the loaded one restarts at its ftw);
        // otherwise only the slot being loaded advances, with natural wrap.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)        acc_q <= '0;
            else if (sync_clr) acc_q <= hit ? inc : '0;
            else if (hit)      acc_q <= acc_q + inc;
        end
    end

    assign rd_phase = sync_clr ? '0 : acc[idx];

endmodule

// File: rtl/nco_frame_scheduler.sv
// NCO frame scheduler: on each accepted sample_tick, walks all channels
// through one shared external sine converter, one slot per cycle, and
// captures the returned samples with a channel tag.
// Optional feature macro: NCO_PHASE_SYNC_EN (adds phase_sync input that
// restarts every accumulator at phase 0 for the accepted frame).
module nco_frame_scheduler
    import nco_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int FTW_W   = DEF_FTW_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IDX_W   = ch_idx_w(NUM_CH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     sample_tick,
    input  logic [NUM_CH*FTW_W-1:0]  ftw,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     overrun_clr,
`ifdef NCO_PHASE_SYNC_EN
    input  logic                     phase_sync,
`endif
    output logic [PHASE_W-1:0]       conv_phase,
    input  logic signed [DATA_W-1:0] conv_data,
    output logic signed [DATA_W-1:0] sample_data,
    output logic [IDX_W-1:0]         sample_ch,
    output logic                     sample_valid,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     overrun
);

    sched_state_t        state, state_nxt;
    logic [IDX_W-1:0]    slot, next_idx, load_idx;
    logic [NUM_CH-1:0]   lat_en;
    logic                accept, step, load, load_en, last_slot, sync_clr;
    logic [PHASE_W-1:0]  rd_phase;

    assign last_slot = (slot == IDX_W'(NUM_CH - 1));
    assign next_idx  = slot + IDX_W'(1);
    assign accept    = (state == IDLE) && enable && sample_tick;
    assign step      = (state == ISSUE) && enable && !last_slot;
    assign load      = accept || step;
    assign load_idx  = accept ? '0 : next_idx;
    // Frame start uses live ch_en (it is being latched on this same edge).
    assign load_en   = accept ? ch_en[0] : lat_en[next_idx];

`ifdef NCO_PHASE_SYNC_EN
    assign sync_clr  = accept && phase_sync;
`else
    assign sync_clr  = 1'b0;
`endif

    nco_phase_bank #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W),
        .FTW_W   (FTW_W),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .adv      (load_en),
        .idx      (load_idx),
        .ftw      (ftw),
        .sync_clr (sync_clr),
        .rd_phase (rd_phase)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: fixed-length frame, aborted to IDLE when enable drops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (!enable) state_nxt = IDLE;
                     else if (last_slot) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: frame_done is suppressed if enable falls during DRAIN.
    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DRAIN) && enable;
    end

    // Slot walk, converter phase register and sample capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot         <= '0;
            lat_en       <= '0;
            conv_phase   <= '0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (accept) begin
                lat_en     <= ch_en;
                slot       <= '0;
                conv_phase <= rd_phase;
            end else if (state == ISSUE && enable) begin
                sample_data  <= conv_data;
                sample_ch    <= slot;
                sample_valid <= lat_en[slot];
                if (step) begin
                    slot       <= next_idx;
                    conv_phase <= rd_phase;
                end
            end
        end
    end

    // Sticky overrun: a tick during a frame sets it, and set beats clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  overrun <= 1'b0;
        else if (sample_tick && busy) overrun <= 1'b1;
        else if (overrun_clr)        overrun <= 1'b0;
    end

endmodule

// File: tb/tb_nco_frame_scheduler.sv
// Directed bench for nco_frame_scheduler with a behavioural converter,
// an accumulator model and a queue of expected samples.
module tb_nco_frame_scheduler;

    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 10;
    localparam int FTW_W   = 10;
    localparam int DATA_W  = 10;

    typedef struct {
        logic [1:0]        ch;
        logic [DATA_W-1:0] data;
        logic              vld;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic sample_tick = 1'b0;
    logic overrun_clr = 1'b0;
    logic [NUM_CH*FTW_W-1:0] ftw = '0;
    logic [NUM_CH-1:0]       ch_en = '0;
`ifdef NCO_PHASE_SYNC_EN
    logic phase_sync = 1'b0;
`endif
    logic [PHASE_W-1:0]       conv_phase;
    logic signed [DATA_W-1:0] conv_data;
    logic signed [DATA_W-1:0] sample_data;
    logic [1:0]               sample_ch;
    logic sample_valid, frame_done, busy, overrun;

    int checks = 0;
    int failures = 0;
    logic [PHASE_W-1:0] acc_m [NUM_CH];
    logic exp_ovr = 1'b0;
    exp_t q[$];

    always #5 clock = ~clock;

    // Behavioural converter: any fixed, phase-distinguishing mapping.
    function automatic logic [DATA_W-1:0] conv_f(input logic [PHASE_W-1:0] p);
        return {p[4:0], p[9:5]} ^ 10'h2a5;
    endfunction

    assign conv_data = conv_f(conv_phase);

    nco_frame_scheduler #(
        .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .FTW_W(FTW_W), .DATA_W(DATA_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sample_tick  (sample_tick),
        .ftw          (ftw),
        .ch_en        (ch_en),
        .overrun_clr  (overrun_clr),
`ifdef NCO_PHASE_SYNC_EN
        .phase_sync   (phase_sync),
`endif
        .conv_phase   (conv_phase),
        .conv_data    (conv_data),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .frame_done   (frame_done),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"},         32'(busy),         32'd0);
        chk({tag, " conv_phase"},   32'(conv_phase),   32'd0);
        chk({tag, " sample_data"},  {22'd0, sample_data}, 32'd0);
        chk({tag, " sample_ch"},    32'(sample_ch),    32'd0);
        chk({tag, " sample_valid"}, 32'(sample_valid), 32'd0);
        chk({tag, " frame_done"},   32'(frame_done),   32'd0);
        chk({tag, " overrun"},      32'(overrun),      32'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_CH; i++) acc_m[i] = '0;
        exp_ovr = 1'b0;
        q.delete();
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock); #1;
        reset = 1'b0;
        #2;
        chk_zero(tag);
        reset = 1'b1;
        clear_model();
    endtask

    task automatic set_ftw_all(input logic [FTW_W-1:0] v);
        for (int i = 0; i < NUM_CH; i++) ftw[i*FTW_W +: FTW_W] = v;
    endtask

    // One frame. ovr_cyc: cycle to inject a busy tick (0 = none), with
    // overrun_clr in the same cycle if ovr_clr. drop_cyc: cycle in which
    // enable goes low (0 = none). Cycle c is the one after edge E(c-1).
    task automatic run_frame(input int ovr_cyc, input bit ovr_clr, input int drop_cyc);
        logic [PHASE_W-1:0] ph [NUM_CH];
        int n_load, n_cap, last_busy, pidx;
        bit bexp;
        exp_t e;
        n_load    = (drop_cyc != 0) ? drop_cyc : NUM_CH;
        n_cap     = (drop_cyc != 0) ? drop_cyc - 1 : NUM_CH;
        last_busy = (drop_cyc != 0) ? drop_cyc : NUM_CH + 1;
        for (int i = 0; i < n_load; i++) begin
            ph[i] = acc_m[i];
            if (ch_en[i]) acc_m[i] = acc_m[i] + PHASE_W'(ftw[i*FTW_W +: FTW_W]);
        end
        for (int i = 0; i < n_cap; i++) begin
            e.ch = 2'(i);
            e.data = conv_f(ph[i]);
            e.vld = ch_en[i];
            q.push_back(e);
        end
        @(posedge clock); #1;
        sample_tick = 1'b1;
        @(posedge clock); #1;
        sample_tick = 1'b0;
        for (int c = 1; c <= NUM_CH + 1; c++) begin
            bexp = (c <= last_busy);
            if (c == ovr_cyc) begin
                sample_tick = 1'b1;
                overrun_clr = ovr_clr;
            end
            if (c == drop_cyc) enable = 1'b0;
            @(negedge clock);
            pidx = ((c < n_load) ? c : n_load) - 1;
            chk($sformatf("busy c%0d", c), 32'(busy), 32'(bexp));
            chk($sformatf("frame_done c%0d", c), 32'(frame_done),
                32'((drop_cyc == 0) && (c == NUM_CH + 1)));
            chk($sformatf("conv_phase c%0d", c), 32'(conv_phase), 32'(ph[pidx]));
            chk($sformatf("overrun c%0d", c), 32'(overrun), 32'(exp_ovr));
            if (c >= 2 && c <= n_cap + 1) begin
                if (q.size() == 0) begin
                    chk($sformatf("scoreboard empty c%0d", c), 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("sample_valid c%0d", c), 32'(sample_valid), 32'(e.vld));
                    chk($sformatf("sample_ch c%0d", c), 32'(sample_ch), 32'(e.ch));
                    chk($sformatf("sample_data c%0d", c), {22'd0, sample_data}, {22'd0, e.data});
                end
            end else begin
                chk($sformatf("sample_valid idle c%0d", c), 32'(sample_valid), 32'd0);
            end
            if (sample_tick && bexp) exp_ovr = 1'b1;
            else if (overrun_clr)    exp_ovr = 1'b0;
            @(posedge clock); #1;
            sample_tick = 1'b0;
            overrun_clr = 1'b0;
        end
        enable = 1'b1;
        @(negedge clock);
        chk("post busy", 32'(busy), 32'd0);
        chk("post sample_valid", 32'(sample_valid), 32'd0);
        chk("post frame_done", 32'(frame_done), 32'd0);
        chk("post overrun", 32'(overrun), 32'(exp_ovr));
        chk("post queue", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #10;
        chk_zero("por");
        reset = 1'b1;
        clear_model();
        enable = 1'b1;

        // Basic frames: all ftw 0x010, all channels on.
        set_ftw_all(10'h010);
        ch_en = 4'b1111;
        run_frame(0, 1'b0, 0);
        run_frame(0, 1'b0, 0);

        // Wrap: channel 0 steps by half a turn.
        do_reset("wrap rst");
        set_ftw_all(10'h010);
        ftw[0 +: FTW_W] = 10'h200;
        repeat (3) run_frame(0, 1'b0, 0);

        // Masking: ch1/ch3 hold, third frame shows the accumulators.
        do_reset("mask rst");
        set_ftw_all(10'h001);
        ch_en = 4'b0101;
        repeat (3) run_frame(0, 1'b0, 0);

        // Overrun: busy tick, idle clear, DRAIN tick, set beats clear.
        do_reset("ovr rst");
        set_ftw_all(10'h010);
        ch_en = 4'b1111;
        run_frame(3, 1'b0, 0);
        @(posedge clock); #1;
        overrun_clr = 1'b1;
        @(posedge clock); #1;
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        @(negedge clock);
        chk("overrun cleared", 32'(overrun), 32'd0);
        run_frame(5, 1'b0, 0);
        run_frame(3, 1'b1, 0);

        // Tick with enable low in IDLE: ignored, no overrun.
        do_reset("en0 rst");
        @(posedge clock); #1;
        enable = 1'b0;
        sample_tick = 1'b1;
        @(posedge clock); #1;
        sample_tick = 1'b0;
        @(negedge clock);
        chk("en0 busy", 32'(busy), 32'd0);
        chk("en0 overrun", 32'(overrun), 32'd0);
        enable = 1'b1;

        // Reset in the middle of a frame after accumulators have moved.
        run_frame(3, 1'b0, 0);
        @(posedge clock); #1;
        sample_tick = 1'b1;
        @(posedge clock); #1;
        sample_tick = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        chk("midframe busy before reset", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_zero("midframe");
        @(posedge clock); #1;
        reset = 1'b1;
        clear_model();
        run_frame(0, 1'b0, 0);

        // Enable drop in cycle 2, then a full frame exposes the accumulators.
        do_reset("drop rst");
        run_frame(0, 1'b0, 2);
        run_frame(0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
